// File: rtl/strobe_period_meter.sv
// Measures the spacing between single-cycle strobes, checks it against an expected period,
// tracks lock over consecutive good periods and flags a missing strobe by timeout.
module strobe_period_meter #(
    parameter int p_WIDTH           = 32,
    parameter int p_EXPECTED_PERIOD = 4,
    parameter int p_TOLERANCE       = 0,
    parameter int p_LOCK_COUNT      = 4,
    parameter int p_TIMEOUT         = 1024
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               i_ENABLE,
    input  logic               i_STROBE,
    output logic [p_WIDTH-1:0] o_PERIOD,
    output logic               o_VALID,
    output logic               o_IN_TOL,
    output logic               o_LOCKED,
    output logic               o_TIMEOUT
);

    localparam int MW = (p_LOCK_COUNT < 2) ? 1 : $clog2(p_LOCK_COUNT + 1);

    localparam logic [p_WIDTH-1:0] EXP_W  = p_WIDTH'(p_EXPECTED_PERIOD);
    localparam logic [p_WIDTH-1:0] TOL_W  = p_WIDTH'(p_TOLERANCE);
    localparam logic [p_WIDTH-1:0] TO_W   = p_WIDTH'(p_TIMEOUT);
    localparam logic [p_WIDTH-1:0] ONE_W  = p_WIDTH'(1);
    localparam logic [MW-1:0]      LOCK_M = MW'(p_LOCK_COUNT);
    localparam logic [MW-1:0]      ONE_M  = MW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [p_WIDTH-1:0] count_q, count_d;
    logic [MW-1:0]      match_q, match_d;
    logic [p_WIDTH-1:0] period_q, period_d;
    logic               valid_q, valid_d;
    logic               in_tol_q, in_tol_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;

    // Period ending on this cycle if a strobe is sampled now; cannot overflow
    // because the timeout always fires before the counter reaches the top.
    logic [p_WIDTH-1:0] period_p;
    logic               period_ok;
    logic [MW-1:0]      match_inc;

    always_comb begin
        period_p = count_q + ONE_W;
        // Compare magnitudes on the larger side only, so no signed wrap occurs.
        if (period_p >= EXP_W) begin
            period_ok = ((period_p - EXP_W) <= TOL_W);
        end else begin
            period_ok = ((EXP_W - period_p) <= TOL_W);
        end
        match_inc = (match_q == LOCK_M) ? match_q : (match_q + ONE_M);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        in_tol_d  = in_tol_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (!i_ENABLE) begin
            state_d   = IDLE;
            count_d   = '0;
            match_d   = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                end
                ARMED: begin
                    if (i_STROBE) begin
                        state_d = MEASURE;
                        count_d = '0;
                    end
                end
                MEASURE: begin
                    if (i_STROBE) begin
                        period_d = period_p;
                        valid_d  = 1'b1;
                        count_d  = '0;
                        in_tol_d = period_ok;
                        if (period_ok) begin
                            match_d  = match_inc;
                            locked_d = (match_inc == LOCK_M);
                        end else begin
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                    end else if (period_p == TO_W) begin
                        state_d   = LOST;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        count_d   = '0;
                    end else begin
                        count_d = period_p;
                    end
                end
                LOST: begin
                    count_d = '0;
                    // The strobe that ends a loss is a fresh first edge, not a period.
                    if (i_STROBE) begin
                        state_d   = MEASURE;
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q   <= IDLE;
            count_q   <= '0;
            match_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            in_tol_q  <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            match_q   <= match_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            in_tol_q  <= in_tol_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_PERIOD  = period_q;
    assign o_VALID   = valid_q;
    assign o_IN_TOL  = in_tol_q;
    assign o_LOCKED  = locked_q;
    assign o_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Three meters (default, tolerance 1, short timeout) share one stimulus stream and are
// compared every cycle against a timestamp-based reference of the measurement rules.
module tb_strobe_period_meter;

    localparam int N = 3;
    localparam int EXP  = 4;
    localparam int LOCK = 4;
    localparam int TOL_T [N] = '{0, 1, 0};
    localparam int TO_T  [N] = '{1024, 1024, 16};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en_r = 1'b0;
    logic st_r = 1'b0;

    logic [31:0] per [N];
    logic        vld [N];
    logic        itl [N];
    logic        lck [N];
    logic        tmo [N];

    always #5 clk = ~clk;

    strobe_period_meter #(.p_WIDTH(32), .p_EXPECTED_PERIOD(EXP), .p_TOLERANCE(0),
                          .p_LOCK_COUNT(LOCK), .p_TIMEOUT(1024)) dut_a (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en_r), .i_STROBE(st_r),
        .o_PERIOD(per[0]), .o_VALID(vld[0]), .o_IN_TOL(itl[0]),
        .o_LOCKED(lck[0]), .o_TIMEOUT(tmo[0]));

    strobe_period_meter #(.p_WIDTH(32), .p_EXPECTED_PERIOD(EXP), .p_TOLERANCE(1),
                          .p_LOCK_COUNT(LOCK), .p_TIMEOUT(1024)) dut_b (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en_r), .i_STROBE(st_r),
        .o_PERIOD(per[1]), .o_VALID(vld[1]), .o_IN_TOL(itl[1]),
        .o_LOCKED(lck[1]), .o_TIMEOUT(tmo[1]));

    strobe_period_meter #(.p_WIDTH(32), .p_EXPECTED_PERIOD(EXP), .p_TOLERANCE(0),
                          .p_LOCK_COUNT(LOCK), .p_TIMEOUT(16)) dut_c (
        .i_CLK(clk), .i_RESET(rst), .i_ENABLE(en_r), .i_STROBE(st_r),
        .o_PERIOD(per[2]), .o_VALID(vld[2]), .o_IN_TOL(itl[2]),
        .o_LOCKED(lck[2]), .o_TIMEOUT(tmo[2]));

    // Reference: mode 0 idle, 1 waiting for first edge, 2 measuring, 3 lost.
    // Periods are the difference of strobe timestamps.
    longint      cyc;
    int          m_mode [N];
    longint      m_last [N];
    int          m_good [N];
    logic [31:0] m_per  [N];
    logic        m_vld  [N];
    logic        m_tol  [N];
    logic        m_lck  [N];
    logic        m_to   [N];

    int n_vec  = 0;
    int n_miss = 0;
    int vld_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0; m_last[i] = 0; m_good[i] = 0; m_per[i] = '0;
            m_vld[i] = 1'b0; m_tol[i] = 1'b0; m_lck[i] = 1'b0; m_to[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        longint p;
        longint d;
        cyc++;
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            if (!en_r) begin
                m_mode[i] = 0; m_good[i] = 0; m_lck[i] = 1'b0; m_to[i] = 1'b0;
            end else begin
                case (m_mode[i])
                    0: m_mode[i] = 1;
                    1: if (st_r) begin m_mode[i] = 2; m_last[i] = cyc; end
                    2: begin
                        if (st_r) begin
                            p = cyc - m_last[i];
                            d = p - EXP;
                            if (d < 0) d = -d;
                            m_per[i] = 32'(p);
                            m_vld[i] = 1'b1;
                            m_tol[i] = (d <= TOL_T[i]);
                            if (m_tol[i]) m_good[i] = (m_good[i] < LOCK) ? m_good[i] + 1 : LOCK;
                            else          m_good[i] = 0;
                            m_lck[i] = (m_good[i] == LOCK);
                            m_last[i] = cyc;
                        end else if (cyc - m_last[i] == TO_T[i]) begin
                            m_mode[i] = 3; m_to[i] = 1'b1; m_lck[i] = 1'b0; m_good[i] = 0;
                        end
                    end
                    default: if (st_r) begin m_mode[i] = 2; m_last[i] = cyc; m_to[i] = 1'b0; end
                endcase
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d_period", i),  per[i], m_per[i]);
            chk($sformatf("d%0d_valid", i),   32'(vld[i]), 32'(m_vld[i]));
            chk($sformatf("d%0d_in_tol", i),  32'(itl[i]), 32'(m_tol[i]));
            chk($sformatf("d%0d_locked", i),  32'(lck[i]), 32'(m_lck[i]));
            chk($sformatf("d%0d_timeout", i), 32'(tmo[i]), 32'(m_to[i]));
        end
    endtask

    task automatic step(input logic en, input logic st);
        en_r = en;
        st_r = st;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (vld[0]) vld_cnt++;
    endtask

    task automatic strobe_gap(input int n);
        for (int k = 1; k < n; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d_rst_async_valid", i), 32'(vld[i]), 32'd0);
            chk($sformatf("d%0d_rst_async_locked", i), 32'(lck[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    function automatic int pick_gap();
        int r;
        r = int'($urandom_range(0, 19));
        if (r <= 10) return 4;
        case (r)
            11: return 3;
            12: return 5;
            13: return 1;
            14: return 2;
            15: return 16;
            16: return 17;
            17: return 15;
            18: return 20;
            default: return int'($urandom_range(6, 12));
        endcase
    endfunction

    initial begin
        int r;
        cyc = 0;
        model_reset();
        #1;
        do_reset();

        // Nominal divider output: first edge silent, then five period-4 measurements.
        step(1'b1, 1'b0);
        vld_cnt = 0;
        strobe_gap(1);
        chk("first_edge_no_valid", 32'(vld[0]), 32'd0);
        for (int k = 0; k < 5; k++) strobe_gap(4);
        chk("nominal_valid_count", 32'(vld_cnt), 32'd5);
        chk("nominal_period", per[0], 32'd4);
        chk("nominal_locked", 32'(lck[0]), 32'd1);

        // One long period: exact meter drops lock, tolerant meter keeps it.
        strobe_gap(5);
        chk("gap5_period", per[0], 32'd5);
        chk("gap5_in_tol", 32'(itl[0]), 32'd0);
        chk("gap5_unlock", 32'(lck[0]), 32'd0);
        chk("gap5_tol1_locked", 32'(lck[1]), 32'd1);
        for (int k = 0; k < 4; k++) strobe_gap(4);
        chk("relock", 32'(lck[0]), 32'd1);

        // Strobes stop: short-timeout meter declares loss, then recovers.
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0);
        chk("lost_timeout", 32'(tmo[2]), 32'd1);
        chk("lost_unlocked", 32'(lck[2]), 32'd0);
        step(1'b1, 1'b1);
        chk("recover_no_valid", 32'(vld[2]), 32'd0);
        chk("recover_timeout_clr", 32'(tmo[2]), 32'd0);
        strobe_gap(4);
        chk("recover_period", per[2], 32'd4);
        strobe_gap(16);
        chk("edge16_valid", 32'(vld[2]), 32'd1);
        chk("edge16_period", per[2], 32'd16);
        chk("edge16_no_timeout", 32'(tmo[2]), 32'd0);

        // Held-high strobe after re-arming.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        vld_cnt = 0;
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("held_valid_count", 32'(vld_cnt), 32'd4);
        chk("held_period", per[0], 32'd1);

        // Lock, then reset mid-period, then re-acquire from scratch.
        for (int k = 0; k < 4; k++) strobe_gap(4);
        step(1'b1, 1'b0);
        do_reset();
        step(1'b1, 1'b0);
        strobe_gap(1);
        for (int k = 0; k < 3; k++) strobe_gap(4);
        chk("post_reset_not_yet", 32'(lck[0]), 32'd0);
        strobe_gap(4);
        chk("post_reset_locked", 32'(lck[0]), 32'd1);

        // One-cycle enable drop while locked.
        step(1'b0, 1'b0);
        chk("en_drop_unlock", 32'(lck[0]), 32'd0);
        chk("en_drop_period_held", per[0], 32'd4);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("en_rearm_no_valid", 32'(vld[0]), 32'd0);

        // Long silence against the default 1024-cycle timeout.
        for (int k = 0; k < 1030; k++) step(1'b1, 1'b0);
        chk("long_timeout", 32'(tmo[0]), 32'd1);
        step(1'b1, 1'b1);

        // Randomized gaps with occasional enable drops and resets.
        for (int it = 0; it < 400; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else if (r < 5) begin
                step(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                strobe_gap(pick_gap());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
